// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready handshake on both sides.
// Bit-serial shifter, one bit per cycle. All results and flags are registered.
module alu_seq #(
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         cf,
  output logic         of,
  output logic         zf,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB = 4'd1,  OP_NOT = 4'd2,  OP_AND = 4'd3,
    OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_SLT = 4'd6,  OP_EQ  = 4'd7,
    OP_SLTU = 4'd8,  OP_SLL = 4'd9,  OP_SRL = 4'd10, OP_SRA = 4'd11
  } op_t;

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           cf_q, cf_d, of_q, of_d, zf_q, zf_d, err_q, err_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [1:0]     sh_op_q, sh_op_d;

  logic [W:0]     sum, diff;
  logic [SW-1:0]  shamt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SW-1:0];

  // Next-state, result and flag computation; out_q doubles as the shift work register.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cf_d    = cf_q;
    of_d    = of_q;
    zf_d    = zf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    sh_op_d = sh_op_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          cf_d    = 1'b0;
          of_d    = 1'b0;
          err_d   = 1'b0;
          case (op)
            OP_ADD: begin
              {cf_d, out_d} = sum;
              of_d = (a[W-1] == b[W-1]) & (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
              out_d = diff[W-1:0];
              cf_d  = diff[W];
              of_d  = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1]);
            end
            OP_NOT:  out_d = ~a;
            OP_AND:  out_d = a & b;
            OP_OR:   out_d = a | b;
            OP_XOR:  out_d = a ^ b;
            OP_SLT:  out_d = W'($signed(a) < $signed(b));
            OP_EQ:   out_d = W'(a == b);
            OP_SLTU: out_d = W'(a < b);
            OP_SLL, OP_SRL, OP_SRA: begin
              out_d   = a;
              cnt_d   = shamt;
              sh_op_d = op[1:0];
              if (shamt != '0) state_d = SHIFT;
            end
            default: begin
              out_d = '0;
              err_d = 1'b1;
            end
          endcase
          zf_d = (out_d == '0);
        end
      end
      SHIFT: begin
        case (sh_op_q)
          2'b01: begin
            out_d = {out_q[W-2:0], 1'b0};
            cf_d  = out_q[W-1];
          end
          2'b10: begin
            out_d = {1'b0, out_q[W-1:1]};
            cf_d  = out_q[0];
          end
          default: begin
            out_d = {out_q[W-1], out_q[W-1:1]};
            cf_d  = out_q[0];
          end
        endcase
        zf_d  = (out_d == '0);
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      sh_op_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sh_op_q <= sh_op_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign cf        = cf_q;
  assign of        = of_q;
  assign zf        = zf_q;
  assign err       = err_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 8: operand/result width; legal values 4..64, power of two.
REQ-002 Parameter SW, default $clog2(W): shift-amount width; derived, not overridden.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/op bundle valid.
REQ-006 in_ready  output  1  block can accept a bundle.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B; shift ops use b[SW-1:0] as shift amount.
REQ-009 op  input  4  operation select (REQ-015).
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  W  result.
REQ-013 cf, of, zf  output  1 each  carry/borrow, signed overflow, zero flag.
REQ-014 err  output  1  op code was reserved.

Function
REQ-015 op encoding: 0 ADD, 1 SUB, 2 NOT(~a), 3 AND, 4 OR, 5 XOR, 6 SLT (signed a<b -> 1 else 0), 7 EQ (a==b -> 1 else 0), 8 SLTU (unsigned), 9 SLL, 10 SRL, 11 SRA, 12-15 reserved.
REQ-016 FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Accept = in_valid & in_ready; a, b, op captured into internal registers on accept; later input changes ignored.
REQ-018 IDLE -> DONE on accept of ops 0-8, 12-15 and shift ops with shamt==0; result visible with out_valid one cycle after accept.
REQ-019 IDLE -> SHIFT on accept of shift op with shamt>0; SHIFT shifts 1 bit per cycle, decrementing a counter; SHIFT -> DONE when counter reaches 0; out_valid asserted exactly shamt+1 cycles after accept.
REQ-020 DONE holds out, cf, of, zf, err stable while out_valid & ~out_ready.
REQ-021 DONE -> IDLE when out_ready=1; in_ready rises the following cycle (no same-cycle re-accept; max throughput 1 op / 2 cycles).
REQ-022 ADD: {cf,out} = a+b (W+1-bit); of = (a[W-1]==b[W-1]) & (out[W-1]!=a[W-1]).
REQ-023 SUB: out = a-b mod 2^W; cf = 1 iff a<b unsigned (borrow); of = (a[W-1]!=b[W-1]) & (out[W-1]!=a[W-1]).
REQ-024 Ops 2-8: cf=0, of=0.
REQ-025 SLL/SRL/SRA: zero-fill, zero-fill, sign-fill respectively; cf = last bit shifted out (0 when shamt==0); of=0.
REQ-026 zf = (out==0) for every op, including reserved.
REQ-027 Reserved ops: out=0, cf=0, of=0, zf=1, err=1; err=0 for all defined ops.
REQ-028 Flags and err registered with out; no output is combinational from a, b or op.
REQ-029 No latches; every output register fully assigned each cycle.

Reset
REQ-030 rst_n=0 forces, asynchronously: state=IDLE, out=0, cf=0, of=0, zf=0, err=0, shift counter=0; hence out_valid=0, in_ready=1 on deassertion.
REQ-031 Reset during SHIFT or DONE aborts the operation; the result is discarded and never presented.
REQ-032 Deassertion is synchronised to clk by the system; first accept possible on the first rising edge with rst_n=1.

Verification (W=8)
REQ-033 ADD a=0x7F b=0x01, out_ready=1 -> next cycle out=0x80, cf=0, of=1, zf=0, err=0.
REQ-034 SUB a=0x03 b=0x05 -> out=0xFE, cf=1, of=0; SUB a=0x05 b=0x05 -> out=0x00, zf=1.
REQ-035 SRA a=0x90 b=0x03 -> out_valid exactly 4 cycles after accept, out=0xF2, cf=0; in_ready low for cycles 1-4.
REQ-036 SLT a=0xFF b=0x01 -> out=0x01; SLTU same operands -> out=0x00, zf=1.
REQ-037 ADD result with out_ready=0 for 3 cycles -> out/flags stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-038 SLL a=0x01 b=0x07, rst_n pulsed low during SHIFT -> out=0, out_valid never asserted, in_ready=1 after release; op=13 -> out=0, zf=1, err=1.
